// File: rtl/vreduction_sequencer_if.sv
// Request/response channels between vector issue, the reduction sequencer
// and writeback. The master side issues requests and consumes responses.
interface vreduction_sequencer_if #(
    parameter int NUM_ELEMENTS = 32
);
    logic                         req_valid;
    logic                         req_ready;
    logic [NUM_ELEMENTS*16-1:0]   req_vector;
    logic [1:0]                   req_type;
    logic [4:0]                   req_imm;
    logic                         req_broadcast;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [NUM_ELEMENTS*16-1:0]   resp_vector;
    logic                         resp_error;

    modport master (
        output req_valid, req_vector, req_type, req_imm, req_broadcast, resp_ready,
        input  req_ready, resp_valid, resp_vector, resp_error
    );

    modport slave (
        input  req_valid, req_vector, req_type, req_imm, req_broadcast, resp_ready,
        output req_ready, resp_valid, resp_vector, resp_error
    );
endinterface

// File: rtl/vreduction_sequencer.sv
// Issue-side sequencer for the vector reduction unit: captures one request,
// clears the unit, streams the operand LANES elements per beat, waits for the
// result (bounded by TIMEOUT) and hands result or timeout error to writeback.
module vreduction_sequencer #(
    parameter int LANES        = 16,
    parameter int NUM_ELEMENTS = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                         CLK,
    input  logic                         nRST,
    vreduction_sequencer_if.slave        io,
    output logic                         ru_clear,
    output logic                         ru_input_valid,
    output logic [LANES*16-1:0]          ru_lane_input,
    output logic [NUM_ELEMENTS*16-1:0]   ru_vector_input,
    output logic [1:0]                   ru_reduction_type,
    output logic [4:0]                   ru_imm,
    output logic                         ru_broadcast,
    input  logic [NUM_ELEMENTS*16-1:0]   ru_vector_output,
    input  logic                         ru_output_valid
);
    localparam int BEATS = NUM_ELEMENTS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef struct packed {
        logic [NUM_ELEMENTS-1:0][15:0] vec;
        logic [1:0]                    typ;
        logic [4:0]                    imm;
        logic                          bcast;
    } req_t;

    req_t                         held;
    logic [2:0]                   state;
    logic [BW-1:0]                beat;
    logic [WW-1:0]                wait_cnt;
    logic [NUM_ELEMENTS*16-1:0]   resp_vec;
    logic                         resp_err;

    // Held operand viewed as BEATS slices so the current beat is a plain index.
    logic [BEATS-1:0][LANES*16-1:0] beat_view;
    assign beat_view = held.vec;

    // Transaction FSM; holding registers only load on request acceptance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            held     <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            resp_vec <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // req_ready is high throughout IDLE, so valid alone completes the handshake
                    if (io.req_valid) begin
                        held.vec   <= io.req_vector;
                        held.typ   <= io.req_type;
                        held.imm   <= io.req_imm;
                        held.bcast <= io.req_broadcast;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    beat  <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (beat == BW'(BEATS - 1)) begin
                        beat     <= '0;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_WAIT: begin
                    // a result arriving on the last allowed cycle still beats the timeout
                    if (ru_output_valid) begin
                        resp_vec <= ru_vector_output;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        resp_vec <= '0;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (io.resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from state or come straight from registers.
    assign io.req_ready       = (state == S_IDLE);
    assign ru_clear           = (state == S_CLEAR);
    assign ru_input_valid     = (state == S_STREAM);
    assign ru_lane_input      = ru_input_valid ? beat_view[beat] : '0;
    assign ru_vector_input    = held.vec;
    assign ru_reduction_type  = held.typ;
    assign ru_imm             = held.imm;
    assign ru_broadcast       = held.bcast;
    assign io.resp_valid      = (state == S_RESP);
    assign io.resp_vector     = resp_vec;
    assign io.resp_error      = resp_err;
endmodule
